bip_control_seq: RTL and testbench

- Parametrised successor to the BIP control unit.
- Adds an explicit run FSM with start/done handshake, conditional and unconditional branches, and configurable data-RAM wait states.
- Sits between program memory (combinational read: Addr in, Data out, same cycle) and the datapath (accumulator, ALU, data RAM).
- Drives the PC, datapath mux selects and RAM strobes.

---
 rtl/bip_pkg.sv | 31 +++
 rtl/bip_decoder_v2.sv | 41 ++++
 rtl/bip_control_seq.sv | 106 ++++++++++
 tb/tb_bip_control_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, accumulator-select encodings, run states and decoded control bundle for the BIP control unit.
package bip_pkg;
  localparam int OPC_W = 5;
  typedef logic [OPC_W-1:0] opcode_t;
  localparam opcode_t OP_HLT  = 5'b00000;
  localparam opcode_t OP_STO  = 5'b00001;
  localparam opcode_t OP_LD   = 5'b00010;
  localparam opcode_t OP_LDI  = 5'b00011;
  localparam opcode_t OP_ADD  = 5'b00100;
  localparam opcode_t OP_ADDI = 5'b00101;
  localparam opcode_t OP_SUB  = 5'b00110;
  localparam opcode_t OP_SUBI = 5'b00111;
  localparam opcode_t OP_BEQ  = 5'b01000;
  localparam opcode_t OP_BNE  = 5'b01001;
  localparam opcode_t OP_JMP  = 5'b01010;
  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;
  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic       is_branch;
    logic       is_halt;
    logic       reads_ram;
  } ctrl_t;
endpackage

// File: rtl/bip_decoder_v2.sv
// bip_decoder_v2: purely combinational opcode to control-bundle decode.
module bip_decoder_v2
  import bip_pkg::*;
(
  input  opcode_t opcode,
  output ctrl_t   ctrl
);
  // opcode bit 1 separates add/sub within both ALU pairs
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT: ctrl.is_halt = 1'b1;
      OP_STO: ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.sel_a     = SELA_RAM;
        ctrl.rd_ram    = 1'b1;
        ctrl.reads_ram = 1'b1;
        ctrl.wr_acc    = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.sel_a     = SELA_ALU;
        ctrl.op        = opcode[1];
        ctrl.rd_ram    = 1'b1;
        ctrl.reads_ram = 1'b1;
        ctrl.wr_acc    = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.op     = opcode[1];
        ctrl.wr_acc = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_JMP: ctrl.is_branch = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/bip_control_seq.sv
// bip_control_seq: BIP run sequencer with start/done handshake, branches and data-RAM wait states.
module bip_control_seq
  import bip_pkg::*;
#(
  parameter int len_data   = 16,
  parameter int len_addr   = 11,
  parameter int len_mux_a  = 2,
  parameter int len_opcode = 5,
  parameter int mem_wait   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_data-1:0]  Data,
  input  logic                 acc_zero,
  output logic [len_addr-1:0]  Addr,
  output logic [len_addr-1:0]  Operand,
  output logic [len_mux_a-1:0] SelA,
  output logic                 SelB,
  output logic                 WrAcc,
  output logic                 Op,
  output logic                 WrRam,
  output logic                 RdRam,
  output logic                 busy,
  output logic                 cpu_done
);
  localparam logic [2:0] WAIT_CYC = 3'(mem_wait);
  state_t              state, state_n;
  logic [len_addr-1:0] pc, pc_n;
  logic [2:0]          cnt, cnt_n;
  opcode_t             opc, opc_q, opc_n, dec_in;
  ctrl_t               ctrl;
  logic                taken, stall;
  assign opc     = OPC_W'(Data[len_data-1 -: len_opcode]);
  assign Operand = Data[len_addr-1:0];
  assign Addr    = pc;
  // WAIT decodes the latched opcode so program memory may change underneath it
  assign dec_in  = state == WAIT ? opc_q : opc;
  bip_decoder_v2 u_dec (.opcode(dec_in), .ctrl(ctrl));
  // JMP has bit 1 set; BEQ/BNE differ in bit 0, which flips the acc_zero sense
  assign taken = ctrl.is_branch && (opc[1] || (opc[0] ^ acc_zero));
  assign stall = ctrl.reads_ram && WAIT_CYC != 3'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
      opc_q <= OP_HLT;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      opc_q <= opc_n;
    end
  end
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = cnt;
    opc_n    = opc_q;
    SelA     = '0;
    SelB     = 1'b0;
    Op       = 1'b0;
    WrAcc    = 1'b0;
    WrRam    = 1'b0;
    RdRam    = 1'b0;
    busy     = state == RUN || state == WAIT;
    cpu_done = state == HALT;
    case (state)
      IDLE, HALT: begin
        state_n = start ? RUN : state;
        pc_n    = start ? '0 : pc;
      end
      RUN: begin
        SelA  = len_mux_a'(ctrl.sel_a);
        SelB  = ctrl.sel_b;
        Op    = ctrl.op;
        WrRam = ctrl.wr_ram;
        RdRam = ctrl.rd_ram;
        WrAcc = ctrl.wr_acc && !stall;
        if (ctrl.is_halt) begin
          state_n = HALT;
        end else if (stall) begin
          state_n = WAIT;
          cnt_n   = WAIT_CYC;
          opc_n   = opc;
        end else begin
          pc_n = taken ? Operand : pc + len_addr'(1);
        end
      end
      WAIT: begin
        SelA  = len_mux_a'(ctrl.sel_a);
        SelB  = ctrl.sel_b;
        Op    = ctrl.op;
        RdRam = 1'b1;
        WrAcc = cnt == 3'd1;
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_n = RUN;
          pc_n    = pc + len_addr'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bip_control_seq.sv
// tb_bip_control_seq: two sequencers (mem_wait 0 and 3) checked against an instruction-level model plus directed vectors.
module tb_bip_control_seq;
  logic clk = 1'b0;
  logic reset, start, acc_zero;
  logic [15:0] prog [0:2047];
  logic [15:0] data [2];
  logic [10:0] addr [2], operand [2];
  logic [1:0]  sela [2];
  logic selb [2], wracc [2], op [2], wrram [2], rdram [2], busy [2], done [2];
  int checks = 0, errors = 0;
  int m_mode [2], m_pc [2], m_el [2];
  logic [15:0] m_ins [2];

  always #5 clk = ~clk;
  assign data[0] = prog[addr[0]];
  assign data[1] = prog[addr[1]];

  bip_control_seq #(.mem_wait(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .Data(data[0]), .acc_zero(acc_zero),
    .Addr(addr[0]), .Operand(operand[0]), .SelA(sela[0]), .SelB(selb[0]), .WrAcc(wracc[0]),
    .Op(op[0]), .WrRam(wrram[0]), .RdRam(rdram[0]), .busy(busy[0]), .cpu_done(done[0]));
  bip_control_seq #(.mem_wait(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .Data(data[1]), .acc_zero(acc_zero),
    .Addr(addr[1]), .Operand(operand[1]), .SelA(sela[1]), .SelB(selb[1]), .WrAcc(wracc[1]),
    .Op(op[1]), .WrRam(wrram[1]), .RdRam(rdram[1]), .busy(busy[1]), .cpu_done(done[1]));

  typedef struct packed {
    logic [10:0] addr;
    logic [10:0] operand;
    logic [1:0]  sela;
    logic selb, op, wracc, wrram, rdram, busy, done;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic        az;
    logic [1:0]  sela;
    logic        selb, op, wracc, wrram, rdram;
    logic [10:0] nxt;
  } vec_t;

  vec_t tbl [15];
  int sa_addr [6] = '{0, 1, 2, 3, 3, 3};
  int sa_wacc [6] = '{1, 1, 0, 0, 0, 0};
  int sa_wram [6] = '{0, 0, 1, 0, 0, 0};
  int sa_done [6] = '{0, 0, 0, 0, 1, 1};
  int sb_rd   [5] = '{1, 1, 1, 1, 0};
  int sb_wacc [5] = '{0, 0, 0, 1, 0};
  int sb_addr [5] = '{0, 0, 0, 0, 1};

  function automatic logic [15:0] ins(logic [4:0] c, logic [10:0] a);
    return {c, a};
  endfunction

  function automatic int mw(int k);
    return k == 0 ? 0 : 3;
  endfunction

  function automatic bit reads(logic [4:0] c);
    return c == 5'd2 || c == 5'd4 || c == 5'd6;
  endfunction

  // Expected outputs from the model's instruction-level view: which instruction, how far into it
  function automatic out_t model_out(int k);
    out_t o;
    logic [4:0] c;
    int dur;
    o = '0;
    o.addr = reset ? 11'd0 : 11'(m_pc[k]);
    o.operand = prog[o.addr][10:0];
    if (reset || m_mode[k] != 1) begin
      o.done = !reset && m_mode[k] == 2;
      return o;
    end
    c = m_el[k] == 0 ? prog[m_pc[k]][15:11] : m_ins[k][15:11];
    dur = reads(c) ? 1 + mw(k) : 1;
    o.busy  = 1'b1;
    o.rdram = reads(c);
    o.wracc = c >= 5'd2 && c <= 5'd7 && m_el[k] == dur - 1;
    o.sela  = c == 5'd3 ? 2'd1 : (c >= 5'd4 && c <= 5'd7) ? 2'd2 : 2'd0;
    o.selb  = c == 5'd5 || c == 5'd7;
    o.op    = c == 5'd6 || c == 5'd7;
    o.wrram = c == 5'd1;
    return o;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] cur;
      logic [4:0] c;
      if (reset) begin
        m_mode[k] = 0; m_pc[k] = 0; m_el[k] = 0;
      end else if (m_mode[k] != 1) begin
        if (start) begin m_mode[k] = 1; m_pc[k] = 0; m_el[k] = 0; end
      end else begin
        if (m_el[k] == 0) m_ins[k] = prog[m_pc[k]];
        cur = m_ins[k];
        c = cur[15:11];
        if (m_el[k] < (reads(c) ? mw(k) : 0)) m_el[k]++;
        else begin
          m_el[k] = 0;
          if (c == 5'd0) m_mode[k] = 2;
          else if (c == 5'd10 || (c == 5'd8 && acc_zero) || (c == 5'd9 && !acc_zero))
            m_pc[k] = int'(cur[10:0]);
          else m_pc[k] = (m_pc[k] + 1) % 2048;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic half();
    out_t a, e;
    #4;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      a = {addr[k], operand[k], sela[k], selb[k], op[k], wracc[k], wrram[k], rdram[k], busy[k], done[k]};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model dut%0d at %0t: got %h expected %h", k, $time, a, e);
      end
    end
  endtask

  task automatic step_edge();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    step_edge();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_zero = 1'b0;
    clear_prog();
    tbl[0]  = '{ins(5'd0,  11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd5};
    tbl[1]  = '{ins(5'd1,  11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd6};
    tbl[2]  = '{ins(5'd2,  11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'd6};
    tbl[3]  = '{ins(5'd3,  11'd20),  1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd6};
    tbl[4]  = '{ins(5'd4,  11'd20),  1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 11'd6};
    tbl[5]  = '{ins(5'd5,  11'd20),  1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd6};
    tbl[6]  = '{ins(5'd6,  11'd20),  1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd6};
    tbl[7]  = '{ins(5'd7,  11'd20),  1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd6};
    tbl[8]  = '{ins(5'd8,  11'd20),  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd20};
    tbl[9]  = '{ins(5'd8,  11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd6};
    tbl[10] = '{ins(5'd9,  11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd20};
    tbl[11] = '{ins(5'd9,  11'd20),  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd6};
    tbl[12] = '{ins(5'd10, 11'h7FF), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h7FF};
    tbl[13] = '{ins(5'd31, 11'd20),  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd6};
    tbl[14] = '{ins(5'd11, 11'd20),  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd6};
    @(posedge clk);
    #1;
    half();
    chk("reset addr", 32'(addr[0]), 32'd0);
    chk("reset strobes", {wracc[0], wrram[0], rdram[0], busy[0], done[0]}, 32'd0);
    chk("reset sel", {sela[1], selb[1], op[1]}, 32'd0);
    step_edge();
    reset = 1'b0;
    tick();

    // single-instruction table, instruction placed at address 5
    for (int i = 0; i < 15; i++) begin
      clear_prog();
      prog[0] = ins(5'd10, 11'd5);
      prog[5] = tbl[i].ins;
      do_reset();
      pulse_start();
      acc_zero = tbl[i].az;
      tick();
      half();
      chk($sformatf("vec%0d ctl", i), {sela[0], selb[0], op[0], wracc[0], wrram[0], rdram[0]},
          {tbl[i].sela, tbl[i].selb, tbl[i].op, tbl[i].wracc, tbl[i].wrram, tbl[i].rdram});
      chk($sformatf("vec%0d busy", i), 32'(busy[0]), 32'd1);
      step_edge();
      half();
      chk($sformatf("vec%0d next", i), 32'(addr[0]), 32'(tbl[i].nxt));
      step_edge();
    end

    // LDI 5; ADDI 3; STO 10; HLT
    clear_prog();
    prog[0] = ins(5'd3, 11'd5); prog[1] = ins(5'd5, 11'd3); prog[2] = ins(5'd1, 11'd10);
    do_reset();
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      half();
      chk($sformatf("prog c%0d addr", c + 1), 32'(addr[0]), 32'(sa_addr[c]));
      chk($sformatf("prog c%0d wracc", c + 1), 32'(wracc[0]), 32'(sa_wacc[c]));
      chk($sformatf("prog c%0d wrram", c + 1), 32'(wrram[0]), 32'(sa_wram[c]));
      chk($sformatf("prog c%0d done", c + 1), 32'(done[0]), 32'(sa_done[c]));
      if (c == 2) chk("prog sto operand", 32'(operand[0]), 32'd10);
      step_edge();
    end

    // LD 7 with three wait states; program word changes under the WAIT
    clear_prog();
    prog[0] = ins(5'd2, 11'd7);
    do_reset();
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) prog[0] = ins(5'd5, 11'd9);
      half();
      chk($sformatf("ldw c%0d rdram", c), 32'(rdram[1]), 32'(sb_rd[c]));
      chk($sformatf("ldw c%0d wracc", c), 32'(wracc[1]), 32'(sb_wacc[c]));
      chk($sformatf("ldw c%0d addr", c), 32'(addr[1]), 32'(sb_addr[c]));
      if (c < 4) chk($sformatf("ldw c%0d sel", c), {sela[1], selb[1], op[1]}, 32'd0);
      step_edge();
    end

    // reset in the middle of a WAIT
    clear_prog();
    prog[0] = ins(5'd10, 11'd4);
    prog[4] = ins(5'd2, 11'd7);
    do_reset();
    pulse_start();
    tick();
    tick();
    tick();
    reset = 1'b1;
    half();
    chk("rstwait addr", 32'(addr[1]), 32'd0);
    chk("rstwait strobes", {wracc[1], wrram[1], rdram[1], busy[1], done[1]}, 32'd0);
    step_edge();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      half();
      chk($sformatf("rstwait idle%0d", c), {addr[1], busy[1], done[1]}, 32'd0);
      step_edge();
    end

    // PC wrap from 0x7FF
    clear_prog();
    prog[0] = ins(5'd10, 11'h7FF);
    prog[2047] = ins(5'd5, 11'd1);
    do_reset();
    pulse_start();
    tick();
    half();
    chk("wrap at top", 32'(addr[0]), 32'h7FF);
    chk("wrap addi wracc", 32'(wracc[0]), 32'd1);
    step_edge();
    half();
    chk("wrap next", 32'(addr[0]), 32'd0);
    step_edge();

    // self-loop with start pulse while busy
    clear_prog();
    prog[0] = ins(5'd10, 11'd0);
    do_reset();
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      start = c == 2;
      half();
      chk($sformatf("loop c%0d", c), {addr[0], busy[0], done[0]}, {11'd0, 1'b1, 1'b0});
      step_edge();
    end
    start = 1'b0;

    // restart from HALT
    clear_prog();
    prog[0] = ins(5'd3, 11'd1);
    do_reset();
    pulse_start();
    tick();
    tick();
    half();
    chk("halt state", {addr[0], busy[0], done[0]}, {11'd1, 1'b0, 1'b1});
    step_edge();
    pulse_start();
    half();
    chk("restart", {addr[0], busy[0], done[0]}, {11'd0, 1'b1, 1'b0});
    step_edge();

    // random programs, inputs and resets against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2048; i++) prog[i] = {5'($urandom_range(0, 15)), 11'($urandom)};
      do_reset();
      for (int n = 0; n < 600; n++) begin
        acc_zero = 1'($urandom);
        start = $urandom_range(0, 5) == 0;
        reset = $urandom_range(0, 149) == 0;
        tick();
      end
      reset = 1'b0;
      start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
